serial_bit_feeder: RTL
======================

# serial_bit_feeder

Parallel-to-serial front end for the sequence-detector stage. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `sout`, whose output drives the detector's serial `in` on the same `clk`. A one-word hold buffer lets back-to-back words stream with no idle gap, so the detector sees a continuous bit stream that can contain overlapping patterns across word boundaries.

## Interface
- `WIDTH`, default 8: word width in bits; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- `IDLE_BIT`, default 1'b0: value driven on `sout` whenever `sout_valid` = 0.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-low (one clock, synchronous active-low reset).
- `din`  in  WIDTH  parallel word.
- `din_valid`  in  1  `din` holds a word.
- `din_ready`  out  1  block can accept a word this cycle.
- `sout`  out  1  serial bit, registered; connects to the detector `in`.
- `sout_valid`  out  1  `sout` carries a real data bit.
- `word_done`  out  1  one-cycle pulse that coincides with the last bit of a word.
- `busy`  out  1  `sout_valid | hold_full`.

## Operation
- Storage:
  - shift register `sh[WIDTH-1:0]`.
  - bit counter `cnt`, width $clog2(WIDTH).
  - hold register `hold[WIDTH-1:0]` plus flag `hold_full`.
  - state register: IDLE or SHIFT.
- Handshake:
  - `din_ready = rst & ~hold_full`. This is combinational from registers and `rst` only, never from `din_valid`.
  - A word is accepted at an edge where `din_valid & din_ready` = 1.
  - `din` may change freely when it is not accepted.
- Load source: when the shifter needs a word, it takes `hold` if `hold_full`. Otherwise it takes the word accepted at that edge, if there is one.
- IDLE state:
  - On accept: `sh ← din`, `cnt ← 0`, go to SHIFT. The hold buffer stays empty.
  - No accept: stay in IDLE.
- SHIFT state, with `cnt < WIDTH-1`:
  - Shift `sh` toward the output end and increment `cnt`.
  - An accepted word goes into `hold` and sets `hold_full`.
- SHIFT state, with `cnt == WIDTH-1` (last bit is on `sout` this cycle):
  - If `hold_full`: `sh ← hold`, clear `hold_full`, `cnt ← 0`, stay in SHIFT.
  - Else if a word is accepted at this edge: `sh ← din`, `cnt ← 0`, stay in SHIFT.
  - Else: go to IDLE.
  - A same-edge accept while `hold_full` = 1 cannot occur, because `din_ready` = 0 then.
- Outputs, all registered:
  - `sout` = `sh[WIDTH-1]` when MSB_FIRST, `sh[0]` otherwise, while in SHIFT; `IDLE_BIT` in IDLE.
  - `sout_valid` = 1 exactly while in SHIFT.
  - `word_done` = `(state==SHIFT) & (cnt==WIDTH-1)`.
- Capacity is at most two words in flight: one in the shifter and one in hold.
- Reset, while `rst` = 0 at an edge:
  - state ← IDLE, `cnt` ← 0, `hold_full` ← 0, `sh` ← 0.
  - `sout` = IDLE_BIT, `sout_valid` = 0, `word_done` = 0, `busy` = 0, `din_ready` = 0.
- Reset in the middle of a word aborts it immediately. No partial word completes, and the held word is discarded.

## Timing
- Latency: word accepted at edge N → first bit on `sout` in the cycle after N, valid until edge N+1.
- A word occupies exactly WIDTH consecutive `sout_valid` cycles. `word_done` is high in the last of them.
- Back-to-back streaming:
  - Bit WIDTH-1 of word k is followed immediately by bit 0 of word k+1.
  - This holds if word k+1 was accepted at any edge from the start of word k up to and including its last-bit edge.
  - There are zero idle cycles in that case.
- `din_ready` falls the cycle after a word enters `hold`. It rises the cycle after `hold` transfers to the shifter.
- After a gap, `sout` returns to IDLE_BIT in the first cycle with `sout_valid` = 0.
- `din_ready` is 1 in the first cycle after `rst` rises.
- The detector samples `sout` at the edge that ends each bit cycle, so one bit is delivered per clock.

## Test plan
- **Single word:** accept 8'hB5 (MSB_FIRST = 1).
  - `sout` = 1,0,1,1,0,1,0,1 on 8 consecutive `sout_valid` cycles.
  - `word_done` is high only on the 8th cycle.
  - Then `sout` = 0 and `busy` = 0.
- **Back-to-back:** hold `din_valid` high with words 8'hB5, 8'h3C, 8'hFF.
  - 16 unbroken `sout_valid` cycles for 8'hB5 then 8'h3C.
  - `din_ready` is low while 8'h3C is held; 8'hFF is accepted on the edge after 8'h3C leaves hold.
  - All 24 bits are continuous.
- **Accept on the last-bit edge:** hold empty, second word offered exactly at the edge where `cnt` = 7.
  - The second word starts with no gap.
  - `hold_full` never sets.
- **LSB first:** MSB_FIRST = 0, WIDTH = 4, word 4'b0011.
  - `sout` = 1,1,0,0, and `word_done` is on the 4th bit.
- **Reset mid-word:** drive `rst` = 0 during bit 3 of 8'hB5 while 8'h3C is held.
  - Next cycle: `sout_valid` = 0, `busy` = 0, `din_ready` = 0.
  - After release, `din_ready` = 1 and no stale bits appear.
- **Chained with the detector:** stream 8'hB5 then 8'h5A into the detector.
  - The detector `out` pulses match a golden bit-level model, including overlapping patterns across the word boundary.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
// Parallel-to-serial front end for the sequence-detector stage. WIDTH-bit words
// arrive over a valid/ready handshake and leave one bit per clock on sout. A
// one-word hold buffer lets consecutive words stream with no idle gap.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   din        in   parallel word
//   din_valid  in   din holds a word
//   din_ready  out  a word can be accepted this cycle (never depends on din_valid)
//   sout       out  serial bit, registered; IDLE_BIT when sout_valid = 0
//   sout_valid out  sout carries a real data bit
//   word_done  out  pulse coinciding with the last bit of a word
//   busy       out  sout_valid | hold_full
module serial_bit_feeder #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic             r_sout;
    logic             r_sout_valid;
    logic             r_word_done;

    state_e           w_state_d;
    logic [WIDTH-1:0] w_sh_d;
    logic [CW-1:0]    w_cnt_d;
    logic [WIDTH-1:0] w_hold_d;
    logic             w_hold_full_d;
    logic             w_accept;
    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;

    assign din_ready  = rst & ~r_hold_full;
    assign busy       = r_sout_valid | r_hold_full;
    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign word_done  = r_word_done;

    always_comb begin
        w_accept      = din_valid & din_ready;
        // Move the next bit to the output end of the shifter.
        w_shifted     = MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
        w_state_d     = r_state;
        w_sh_d        = r_sh;
        w_cnt_d       = r_cnt;
        w_hold_d      = r_hold;
        w_hold_full_d = r_hold_full;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_sh_d    = din;
                    w_cnt_d   = '0;
                    w_state_d = StShift;
                end
            end
            StShift: begin
                if (r_cnt != LAST) begin
                    w_sh_d  = w_shifted;
                    w_cnt_d = r_cnt + CW'(1);
                    if (w_accept) begin
                        w_hold_d      = din;
                        w_hold_full_d = 1'b1;
                    end
                end else if (r_hold_full) begin
                    // din_ready is low here, so no same-edge accept can collide.
                    w_sh_d        = r_hold;
                    w_hold_full_d = 1'b0;
                    w_cnt_d       = '0;
                end else if (w_accept) begin
                    w_sh_d  = din;
                    w_cnt_d = '0;
                end else begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        w_out_bit = MSB_FIRST ? w_sh_d[WIDTH-1] : w_sh_d[0];
    end

    // Outputs are registered from next-state values so they line up with the
    // shifter contents in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_sh         <= '0;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_sout       <= IDLE_BIT;
            r_sout_valid <= 1'b0;
            r_word_done  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_sh         <= w_sh_d;
            r_cnt        <= w_cnt_d;
            r_hold       <= w_hold_d;
            r_hold_full  <= w_hold_full_d;
            r_sout       <= (w_state_d == StShift) ? w_out_bit : IDLE_BIT;
            r_sout_valid <= (w_state_d == StShift);
            r_word_done  <= (w_state_d == StShift) && (w_cnt_d == LAST);
        end
    end

endmodule
